// File: rtl/wb_ext_arbiter.sv
// wb_ext_arbiter: round-robin arbiter sharing one Wishbone slave among many
// compute-tile masters, with a per-strobe wait timeout that aborts with an error.
module wb_ext_arbiter #(
  parameter int NUM_MASTERS = 36,
  parameter int TIMEOUT = 255,
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS*32-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cab_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS*32-1:0] m_dat_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic                      s_cab_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic                      s_ack_i,
  input  logic                      s_rty_i,
  input  logic                      s_err_i,
  input  logic [31:0]               s_dat_i,
  output logic [IDW-1:0]            grant_o,
  output logic                      busy_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  logic [1:0] state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, last_q, last_d, nxt_g;
  logic [15:0] cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] sel;
  logic [31:0] g_adr, g_dat;
  logic [3:0] g_sel;
  logic [2:0] g_cti;
  logic [1:0] g_bte;
  logic g_cyc, g_stb, g_we, g_cab, gnt, abt, resp;
  int d, best;
  always_comb begin
    sel = '0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we = 1'b0;
    g_cab = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == IDW'(i)) begin
        sel[i] = 1'b1;
        g_adr = m_adr_i[i*32 +: 32];
        g_dat = m_dat_i[i*32 +: 32];
        g_sel = m_sel_i[i*4 +: 4];
        g_cti = m_cti_i[i*3 +: 3];
        g_bte = m_bte_i[i*2 +: 2];
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
        g_we = m_we_i[i];
        g_cab = m_cab_i[i];
      end
    end
  end
  // d is the round-robin distance from last_q+1; the closest requester wins
  always_comb begin
    nxt_g = grant_q;
    best = NUM_MASTERS;
    d = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      d = (i + NUM_MASTERS - 1 - int'(last_q)) % NUM_MASTERS;
      if (m_cyc_i[i] && d < best) begin
        best = d;
        nxt_g = IDW'(i);
      end
    end
  end
  assign gnt = state_q == GRANT;
  assign abt = state_q == ABORT;
  assign resp = s_ack_i | s_rty_i | s_err_i;
  // in ABORT the counter doubles as a first-cycle marker for the error pulse
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (|m_cyc_i) begin
        state_d = GRANT;
        grant_d = nxt_g;
      end
    end else if (!g_cyc) begin
      state_d = IDLE;
      last_d = grant_q;
      cnt_d = '0;
    end else if (abt) cnt_d = 16'd1;
    else if (resp || !g_stb) cnt_d = '0;
    else if (cnt_q == TMO) begin
      state_d = ABORT;
      cnt_d = '0;
    end else cnt_d = cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IDW'(NUM_MASTERS - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign s_adr_o = gnt ? g_adr : '0;
  assign s_dat_o = gnt ? g_dat : '0;
  assign s_sel_o = gnt ? g_sel : '0;
  assign s_cti_o = gnt ? g_cti : '0;
  assign s_bte_o = gnt ? g_bte : '0;
  assign s_cyc_o = gnt & g_cyc;
  assign s_stb_o = gnt & g_stb;
  assign s_we_o = gnt & g_we;
  assign s_cab_o = gnt & g_cab;
  assign m_ack_o = (gnt && s_ack_i) ? sel : '0;
  assign m_rty_o = (gnt && s_rty_i) ? sel : '0;
  assign m_err_o = ((gnt && s_err_i) || (abt && cnt_q == '0)) ? sel : '0;
  assign m_dat_o = {NUM_MASTERS{s_dat_i}};
  assign grant_o = grant_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_wb_ext_arbiter.sv
// tb_wb_ext_arbiter: directed checks of grant order, bursts, timeout abort,
// timeout-boundary response and asynchronous reset for wb_ext_arbiter.
module tb_wb_ext_arbiter;
  localparam int N = 36;
  localparam int IDW = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*32-1:0] m_adr = '0, m_dat = '0, m_dat_o;
  logic [N*4-1:0] m_sel = '1;
  logic [N-1:0] m_cyc = '0, m_stb = '0, m_we = '0, m_cab = '0;
  logic [N*3-1:0] m_cti = '0;
  logic [N*2-1:0] m_bte = '0;
  logic [N-1:0] m_ack_o, m_rty_o, m_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat = '0;
  logic [3:0] s_sel_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_cab_o, busy_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;
  logic s_ack = 1'b0, s_rty = 1'b0, s_err = 1'b0;
  logic [IDW-1:0] grant_o;
  int nvec = 0;
  int nerr = 0;
  int ord[3] = '{0, 3, 35};
  logic [63:0] oh[3] = '{64'h1, 64'h8, 64'h8_0000_0000};
  wb_ext_arbiter #(.NUM_MASTERS(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cyc_i(m_cyc),
    .m_stb_i(m_stb), .m_we_i(m_we), .m_cab_i(m_cab), .m_cti_i(m_cti),
    .m_bte_i(m_bte), .m_ack_o(m_ack_o), .m_rty_o(m_rty_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_ack_i(s_ack), .s_rty_i(s_rty),
    .s_err_i(s_err), .s_dat_i(s_dat), .grant_o(grant_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic set_m(input int i, input logic cyc, input logic stb, input logic [31:0] adr, input logic [2:0] cti);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_adr[i*32 +: 32] = adr;
    m_cti[i*3 +: 3] = cti;
  endtask
  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not reach the end");
  end
  initial begin
    #3;
    chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_resp", 64'({m_ack_o, m_rty_o, m_err_o}), 64'h0);
    tick();
    tick();
    rst = 1'b1;
    // single read from master 5
    set_m(5, 1, 1, 32'h100, 3'd0);
    #1 chk("rd_req_cycle_s_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    #1 chk("rd_s_cyc", 64'(s_cyc_o), 64'h1);
    chk("rd_grant", 64'(grant_o), 64'd5);
    chk("rd_s_adr", 64'(s_adr_o), 64'h100);
    chk("rd_no_ack_yet", 64'(m_ack_o), 64'h0);
    tick();
    s_ack = 1'b1;
    s_dat = 32'hCAFE;
    #1 chk("rd_ack", 64'(m_ack_o), 64'h20);
    chk("rd_dat5", 64'(m_dat_o[5*32 +: 32]), 64'hCAFE);
    tick();
    s_ack = 1'b0;
    set_m(5, 0, 0, 32'h0, 3'd0);
    #1 chk("rd_ack_once", 64'(m_ack_o), 64'h0);
    tick();
    #1 chk("rd_idle_busy", 64'(busy_o), 64'h0);
    chk("rd_last_grant", 64'(grant_o), 64'd5);
    // round robin 0, 3, 35 after a fresh reset
    rst = 1'b0;
    #1 chk("rr_rst_grant", 64'(grant_o), 64'h0);
    tick();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) set_m(ord[j], 1, 1, 32'h1000 + 32'(ord[j]), 3'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      #1 chk("rr_grant", 64'(grant_o), 64'(ord[j]));
      chk("rr_s_adr", 64'(s_adr_o), 64'h1000 + 64'(ord[j]));
      chk("rr_s_cyc", 64'(s_cyc_o), 64'h1);
      s_ack = 1'b1;
      #1 chk("rr_ack", 64'(m_ack_o), oh[j]);
      tick();
      s_ack = 1'b0;
      set_m(ord[j], 0, 0, 32'h0, 3'd0);
      tick();
      #1 chk("rr_dead_cycle", 64'(busy_o), 64'h0);
    end
    // 4-beat burst by master 7 while master 8 waits
    set_m(7, 1, 1, 32'h200, 3'b010);
    tick();
    set_m(8, 1, 1, 32'h300, 3'b000);
    for (int b = 0; b < 4; b++) begin
      set_m(7, 1, 1, 32'h200 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
      s_ack = 1'b1;
      #1 chk("bu_ack7", 64'(m_ack_o), 64'h80);
      chk("bu_s_adr", 64'(s_adr_o), 64'h200 + 64'(4 * b));
      chk("bu_s_cti", 64'(s_cti_o), (b == 3) ? 64'h7 : 64'h2);
      tick();
    end
    s_ack = 1'b0;
    set_m(7, 0, 0, 32'h0, 3'd0);
    #1 chk("bu_grant_held", 64'(grant_o), 64'd7);
    chk("bu_no_ack", 64'(m_ack_o), 64'h0);
    tick();
    #1 chk("bu_dead_cycle", 64'(busy_o), 64'h0);
    tick();
    #1 chk("bu_grant8", 64'(grant_o), 64'd8);
    chk("bu_s_adr8", 64'(s_adr_o), 64'h300);
    // timeout: slave silent toward master 8
    for (int t = 0; t < 5; t++) begin
      chk("to_stb_high", 64'(s_stb_o), 64'h1);
      chk("to_no_err", 64'(m_err_o), 64'h0);
      tick();
      #1;
    end
    chk("to_abort_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("to_err_pulse", 64'(m_err_o), 64'h100);
    chk("to_abort_busy", 64'(busy_o), 64'h1);
    tick();
    #1 chk("to_err_once", 64'(m_err_o), 64'h0);
    chk("to_abort_hold", 64'(busy_o), 64'h1);
    set_m(8, 0, 0, 32'h0, 3'd0);
    tick();
    #1 chk("to_idle", 64'(busy_o), 64'h0);
    // ack arrives exactly when the counter equals TIMEOUT
    set_m(9, 1, 1, 32'h400, 3'd0);
    tick();
    #1 chk("bd_grant9", 64'(grant_o), 64'd9);
    for (int t = 0; t < 4; t++) tick();
    s_ack = 1'b1;
    #1 chk("bd_ack", 64'(m_ack_o), 64'h200);
    chk("bd_no_err", 64'(m_err_o), 64'h0);
    tick();
    s_ack = 1'b0;
    #1 chk("bd_still_grant", 64'(s_cyc_o), 64'h1);
    chk("bd_no_err_after", 64'(m_err_o), 64'h0);
    set_m(9, 0, 0, 32'h0, 3'd0);
    tick();
    #1 chk("bd_idle", 64'(busy_o), 64'h0);
    // reset during master 2's second beat
    set_m(2, 1, 1, 32'h500, 3'b010);
    tick();
    #1 chk("rs_grant2", 64'(grant_o), 64'd2);
    s_ack = 1'b1;
    #1 chk("rs_ack2", 64'(m_ack_o), 64'h4);
    tick();
    set_m(2, 1, 1, 32'h504, 3'b010);
    #1 rst = 1'b0;
    #1 chk("rs_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("rs_ack", 64'(m_ack_o), 64'h0);
    chk("rs_err", 64'(m_err_o), 64'h0);
    chk("rs_busy", 64'(busy_o), 64'h0);
    chk("rs_grant", 64'(grant_o), 64'h0);
    tick();
    s_ack = 1'b0;
    set_m(0, 1, 1, 32'h600, 3'd0);
    rst = 1'b1;
    #1 chk("rs_idle_after", 64'(busy_o), 64'h0);
    tick();
    #1 chk("rs_master0_wins", 64'(grant_o), 64'h0);
    chk("rs_s_adr0", 64'(s_adr_o), 64'h600);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
